// File: rtl/writeback_unit.sv
// Writeback stage feeding the register file's single write port.
// Merges ALU results with buffered load responses and tracks per-register load hazards.
module writeback_unit #(
   parameter int DATA_W     = 4,
   parameter int ADDR_W     = 2,
   parameter int NUM_REGS   = 4,
   parameter int LBUF_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alu_valid,
   input  logic [ADDR_W-1:0]   alu_rd,
   input  logic [DATA_W-1:0]   alu_data,
   input  logic                load_issue,
   input  logic [ADDR_W-1:0]   load_rd,
   input  logic                load_resp_valid,
   input  logic [ADDR_W-1:0]   load_resp_rd,
   input  logic [DATA_W-1:0]   load_resp_data,
   output logic                load_resp_ready,
   input  logic                dec_valid,
   input  logic [ADDR_W-1:0]   dec_rs1,
   input  logic [ADDR_W-1:0]   dec_rs2,
   input  logic [ADDR_W-1:0]   dec_rd,
   output logic                stall,
   output logic                wb_en,
   output logic [ADDR_W-1:0]   wb_reg,
   output logic [DATA_W-1:0]   wb_data,
   output logic [NUM_REGS-1:0] busy,
   output logic                resp_err
);

   localparam int PTR_W = (LBUF_DEPTH > 1) ? $clog2(LBUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(LBUF_DEPTH + 1);

   logic [ADDR_W-1:0]   buf_rd   [LBUF_DEPTH];
   logic [DATA_W-1:0]   buf_data [LBUF_DEPTH];
   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [CNT_W-1:0]    count;
   logic                accept;
   logic                pop;
   logic [NUM_REGS-1:0] busy_next;

   // Ready depends only on registered occupancy, so a pop cannot open a full buffer early.
   assign load_resp_ready = (count < CNT_W'(LBUF_DEPTH));
   assign accept          = load_resp_valid && load_resp_ready;
   assign pop             = !alu_valid && (count != '0);

   assign stall = dec_valid && (busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd] |
                  (wb_en && ((wb_reg == dec_rs1) || (wb_reg == dec_rs2))));

   always_ff @(posedge clk) begin
      if (accept) begin
         buf_rd[tail]   <= load_resp_rd;
         buf_data[tail] <= load_resp_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (pop)
            head <= head + PTR_W'(1);
         if (accept)
            tail <= tail + PTR_W'(1);
         case ({accept, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // A new load to a register being retired this cycle must leave it busy.
   always_comb begin
      busy_next = busy;
      if (pop)
         busy_next[buf_rd[head]] = 1'b0;
      if (load_issue)
         busy_next[load_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         resp_err <= 1'b0;
      end else begin
         busy <= busy_next;
         if (accept && !busy[load_resp_rd])
            resp_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_en   <= 1'b0;
         wb_reg  <= '0;
         wb_data <= '0;
      end else if (alu_valid) begin
         wb_en   <= 1'b1;
         wb_reg  <= alu_rd;
         wb_data <= alu_data;
      end else if (pop) begin
         wb_en   <= 1'b1;
         wb_reg  <= buf_rd[head];
         wb_data <= buf_data[head];
      end else begin
         wb_en   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: randomized traffic against a queue-based
// reference model, followed by directed reset, ALU, load, collision and error scenarios.
module tb_writeback_unit;

   localparam int DEPTH = 2;

   logic       clk;
   logic       rst_n;
   logic       alu_valid;
   logic [1:0] alu_rd;
   logic [3:0] alu_data;
   logic       load_issue;
   logic [1:0] load_rd;
   logic       load_resp_valid;
   logic [1:0] load_resp_rd;
   logic [3:0] load_resp_data;
   logic       load_resp_ready;
   logic       dec_valid;
   logic [1:0] dec_rs1;
   logic [1:0] dec_rs2;
   logic [1:0] dec_rd;
   logic       stall;
   logic       wb_en;
   logic [1:0] wb_reg;
   logic [3:0] wb_data;
   logic [3:0] busy;
   logic       resp_err;

   int errors = 0;
   int checks = 0;

   // Reference model: pending responses as a FIFO, plus busy bits and last write.
   int       q_rd[$];
   int       q_data[$];
   bit [3:0] m_busy;
   bit       m_wb_en;
   int       m_wb_reg;
   int       m_wb_data;
   bit       m_err;

   writeback_unit dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .load_issue(load_issue), .load_rd(load_rd),
      .load_resp_valid(load_resp_valid), .load_resp_rd(load_resp_rd),
      .load_resp_data(load_resp_data), .load_resp_ready(load_resp_ready),
      .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .stall(stall), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .busy(busy), .resp_err(resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int av, input int ar, input int ad,
                                input int li, input int lr,
                                input int rv, input int rr, input int rdat,
                                input int dv, input int s1, input int s2, input int dd);
      alu_valid       = av[0];
      alu_rd          = 2'(ar);
      alu_data        = 4'(ad);
      load_issue      = li[0];
      load_rd         = 2'(lr);
      load_resp_valid = rv[0];
      load_resp_rd    = 2'(rr);
      load_resp_data  = 4'(rdat);
      dec_valid       = dv[0];
      dec_rs1         = 2'(s1);
      dec_rs2         = 2'(s2);
      dec_rd          = 2'(dd);
   endtask

   task automatic applyIdle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic resetModel();
      q_rd.delete();
      q_data.delete();
      m_busy    = '0;
      m_wb_en   = 1'b0;
      m_wb_reg  = 0;
      m_wb_data = 0;
      m_err     = 1'b0;
   endtask

   // Compare DUT against the model for the current cycle, then advance the model
   // with the inputs that the coming rising edge will sample.
   task automatic evalCycle();
      bit       exp_stall;
      bit       acc;
      bit       pop;
      bit [3:0] nb;
      #1;
      exp_stall = dec_valid && (m_busy[dec_rs1] || m_busy[dec_rs2] || m_busy[dec_rd] ||
                  (m_wb_en && (m_wb_reg == int'(dec_rs1) || m_wb_reg == int'(dec_rs2))));
      checkOutput("wb_en", int'(wb_en), int'(m_wb_en));
      checkOutput("wb_reg", int'(wb_reg), m_wb_reg);
      checkOutput("wb_data", int'(wb_data), m_wb_data);
      checkOutput("busy", int'(busy), int'(m_busy));
      checkOutput("resp_err", int'(resp_err), int'(m_err));
      checkOutput("ready", int'(load_resp_ready), int'(q_rd.size() < DEPTH));
      checkOutput("stall", int'(stall), int'(exp_stall));

      acc = load_resp_valid && (q_rd.size() < DEPTH);
      pop = !alu_valid && (q_rd.size() > 0);
      if (acc && !m_busy[load_resp_rd])
         m_err = 1'b1;
      nb = m_busy;
      if (pop)
         nb[q_rd[0]] = 1'b0;
      if (load_issue)
         nb[load_rd] = 1'b1;
      m_busy = nb;
      if (alu_valid) begin
         m_wb_en   = 1'b1;
         m_wb_reg  = int'(alu_rd);
         m_wb_data = int'(alu_data);
      end else if (pop) begin
         m_wb_en   = 1'b1;
         m_wb_reg  = q_rd[0];
         m_wb_data = q_data[0];
      end else begin
         m_wb_en = 1'b0;
      end
      if (pop) begin
         void'(q_rd.pop_front());
         void'(q_data.pop_front());
      end
      if (acc) begin
         q_rd.push_back(int'(load_resp_rd));
         q_data.push_back(int'(load_resp_data));
      end
   endtask

   task automatic step();
      evalCycle();
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyIdle();
         step();
      end
   endtask

   task automatic assertReset();
      applyIdle();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_wb_en", int'(wb_en), 0);
      checkOutput("rst_wb_reg", int'(wb_reg), 0);
      checkOutput("rst_wb_data", int'(wb_data), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_ready", int'(load_resp_ready), 1);
      checkOutput("rst_resp_err", int'(resp_err), 0);
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int pickReg(input bit want_busy);
      int cand[$];
      for (int i = 0; i < 4; i++)
         if (m_busy[i] == want_busy)
            cand.push_back(i);
      if (cand.size() == 0)
         return -1;
      return cand[$urandom_range(cand.size() - 1, 0)];
   endfunction

   initial begin
      int a;
      int l;
      int r;
      int av;
      int li;
      int rv;
      applyIdle();
      resetModel();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized legal traffic: ALU and issue target free registers, responses busy ones.
      for (int c = 0; c < 400; c++) begin
         a  = pickReg(1'b0);
         l  = pickReg(1'b0);
         r  = pickReg(1'b1);
         av = (a >= 0 && ($urandom % 2) == 0) ? 1 : 0;
         li = (l >= 0 && ($urandom % 4) == 0 && !(av == 1 && l == a)) ? 1 : 0;
         rv = (r >= 0 && ($urandom % 3) == 0) ? 1 : 0;
         applyStimulus(av, (a < 0) ? 0 : a, int'($urandom % 16),
                       li, (l < 0) ? 0 : l,
                       rv, (r < 0) ? 0 : r, int'($urandom % 16),
                       int'($urandom % 2), int'($urandom % 4), int'($urandom % 4),
                       int'($urandom % 4));
         step();
      end
      idleCycles(6);
      assertReset();

      // ALU write and one-cycle commit window stall.
      applyStimulus(1, 2, 'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
      evalCycle();
      checkOutput("alu_wb_en", int'(wb_en), 1);
      checkOutput("alu_wb_reg", int'(wb_reg), 2);
      checkOutput("alu_wb_data", int'(wb_data), 'hA);
      checkOutput("alu_stall_c1", int'(stall), 1);
      @(negedge clk);
      evalCycle();
      checkOutput("alu_stall_c2", int'(stall), 0);
      @(negedge clk);

      // Load issue, stall on busy source, response with minimum latency.
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      evalCycle();
      checkOutput("ld_busy", int'(busy), 'b0010);
      checkOutput("ld_stall", int'(stall), 1);
      @(negedge clk);
      idleCycles(1);
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0);
      step();
      idleCycles(1);
      applyIdle();
      evalCycle();
      checkOutput("ld_wb_en", int'(wb_en), 1);
      checkOutput("ld_wb_reg", int'(wb_reg), 1);
      checkOutput("ld_wb_data", int'(wb_data), 5);
      checkOutput("ld_busy_clr", int'(busy), 0);
      @(negedge clk);

      // Collision: responses buffered behind continuous ALU writes; set-wins on rd 3.
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      applyStimulus(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      step();
      applyStimulus(1, 1, 3, 0, 0, 1, 0, 7, 0, 0, 0, 0);
      step();
      applyStimulus(1, 2, 4, 0, 0, 1, 3, 9, 0, 0, 0, 0);
      step();
      applyStimulus(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      evalCycle();
      checkOutput("col_ready", int'(load_resp_ready), 0);
      @(negedge clk);
      applyStimulus(1, 2, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      idleCycles(1);
      applyStimulus(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      evalCycle();
      checkOutput("col_wb_reg0", int'(wb_reg), 0);
      checkOutput("col_wb_data0", int'(wb_data), 7);
      @(negedge clk);
      applyIdle();
      evalCycle();
      checkOutput("col_wb_reg3", int'(wb_reg), 3);
      checkOutput("col_wb_data3", int'(wb_data), 9);
      checkOutput("setwins_busy", int'(busy), 'b1000);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0);
      step();
      idleCycles(3);

      // Reset mid-traffic with two buffered responses.
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      step();
      applyStimulus(1, 2, 1, 0, 0, 1, 0, 2, 0, 0, 0, 0);
      step();
      applyStimulus(1, 3, 3, 0, 0, 1, 1, 4, 0, 0, 0, 0);
      step();
      assertReset();
      idleCycles(3);

      // Response for a non-busy register: sticky error, data still written.
      applyStimulus(0, 0, 0, 0, 0, 1, 2, 'hC, 0, 0, 0, 0);
      step();
      applyIdle();
      evalCycle();
      checkOutput("err_set", int'(resp_err), 1);
      @(negedge clk);
      evalCycle();
      checkOutput("err_wb_reg", int'(wb_reg), 2);
      checkOutput("err_wb_data", int'(wb_data), 'hC);
      @(negedge clk);
      idleCycles(3);
      evalCycle();
      checkOutput("err_sticky", int'(resp_err), 1);
      @(negedge clk);
      assertReset();
      idleCycles(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage directly upstream of the 4-entry register file; the register file's single write port is driven only by this block.
- Merges same-cycle ALU results and out-of-order-timed load responses into one registered write.
- Buffers load responses that collide with ALU writes.
- Keeps a per-register busy scoreboard and raises a decode stall on RAW/WAW hazards.

Parameters:
DATA_W, 4, register data width
ADDR_W, 2, register index width
NUM_REGS, 4, number of architectural registers (2**ADDR_W)
LBUF_DEPTH, 2, load-response buffer entries (power of two, >=2)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result present this cycle
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
load_issue  input  1  load issued this cycle; marks load_rd busy
load_rd  input  ADDR_W  destination of issued load
load_resp_valid  input  1  memory load data valid
load_resp_rd  input  ADDR_W  destination of returning load
load_resp_data  input  DATA_W  returned load data
load_resp_ready  output  1  buffer can accept a response
dec_valid  input  1  decode stage holds an instruction
dec_rs1  input  ADDR_W  decode source 1
dec_rs2  input  ADDR_W  decode source 2
dec_rd  input  ADDR_W  decode destination
stall  output  1  hold decode this cycle
wb_en  output  1  register-file write enable (to reg_write)
wb_reg  output  ADDR_W  register-file write index
wb_data  output  DATA_W  register-file write data
busy  output  NUM_REGS  scoreboard bits, bit i = register i awaiting load
resp_err  output  1  sticky: response arrived for non-busy register

Behaviour:
- Reset (rst_n low, async):
  - wb_en=0, wb_reg=0, wb_data=0, busy=0, resp_err=0.
  - Buffer emptied; load_resp_ready=1 from first cycle after release.
  - Reset mid-operation discards buffered responses and all outstanding busy bits.
- Write output is registered: the source selected in cycle N appears on wb_* in cycle N+1 for exactly one cycle. The register file commits it at the end of N+1.
- Source priority each cycle:
  1. alu_valid: wb_* <= {1, alu_rd, alu_data}.
  2. Else if buffer non-empty: pop head, wb_* <= {1, head.rd, head.data}.
  3. Else wb_en <= 0; wb_reg/wb_data hold previous values.
- Load path:
  - Response accepted on load_resp_valid && load_resp_ready and pushed to the buffer tail.
  - Minimum load latency: accept in N, pop in N+1, wb_en in N+2.
  - load_resp_ready = (count < LBUF_DEPTH), registered-state only. When full, a same-cycle pop does not make ready high.
  - Buffer is FIFO-ordered; pointers wrap modulo LBUF_DEPTH.
- Scoreboard:
  - load_issue sets busy[load_rd] at the clock edge.
  - A pop from the buffer clears busy[head.rd] at the same edge that loads wb_*.
  - Set and clear of the same index in one cycle: set wins.
  - Accepting a response whose busy[load_resp_rd]=0 sets resp_err (sticky until reset). The data is still written.
- Stall (combinational):
  - stall = dec_valid && (busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd] | (wb_en && wb_reg in {dec_rs1, dec_rs2})).
  - The wb_en term covers the one-cycle window before the register file commits.
  - Upstream issues alu_valid or load_issue only for instructions that passed decode with stall=0.
- ALU and buffer targeting the same rd in one cycle is impossible by construction (rd busy => stall).
- Simultaneous alu_valid and load accept: ALU goes to wb; the response is buffered, not lost.

Test Plan:
- Reset: rst_n low mid-traffic with buffer count=2 -> wb_en=0, busy=0000, load_resp_ready=1, resp_err=0 next cycle.
- ALU write: alu_valid=1, alu_rd=2, alu_data=4'hA in cycle 0 -> cycle 1 wb_en=1, wb_reg=2, wb_data=A; cycle 1 with dec_rs1=2, dec_valid=1 -> stall=1; cycle 2 -> stall=0.
- Load: load_issue rd=1 at cycle 0 -> busy=0010; dec_rs2=1 stalls. Response rd=1, data=5 at cycle 3 -> cycle 5 wb_en=1, wb_reg=1, wb_data=5; busy=0000 from cycle 5.
- Collision: alu_valid=1 continuously for cycles 0-3 with responses for rd=0 and rd=3 in cycles 0-1 -> load_resp_ready=0 in cycle 2. Once ALU stops in cycle 4: wb rd=0 in cycle 5, then rd=3 in cycle 6; no response lost.
- Set-wins: pop clearing busy[3] in the same cycle as load_issue rd=3 -> busy[3]=1 afterwards.
- Error: response rd=2 with busy[2]=0 -> resp_err=1 held until reset; wb_reg=2 still written.
